// File: rtl/id_queue_pkg.sv
// id_queue_pkg
// Shared constants for the instruction decode queue:
//   - TYPE_R / TYPE_I / TYPE_J : one-hot op-type encodings {R,I,J}
//   - OP_SPECIAL / OP_J / OP_JAL : opcodes that select R and J types
//   - *_MSB / *_LSB : MIPS field positions inside an instruction word
//   - op_type_of() : opcode to one-hot op-type mapping
package id_queue_pkg;

   localparam logic [2:0] TYPE_R = 3'b100;
   localparam logic [2:0] TYPE_I = 3'b010;
   localparam logic [2:0] TYPE_J = 3'b001;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;

   // Any opcode that is neither SPECIAL nor a jump is treated as I-type.
   function automatic logic [2:0] op_type_of(input logic [5:0] opcode);
      case (opcode)
         OP_SPECIAL:  return TYPE_R;
         OP_J, OP_JAL: return TYPE_J;
         default:     return TYPE_I;
      endcase
   endfunction

endpackage

// File: rtl/id_queue_if.sv
// id_queue_if
// Fetch-side and decode-side handshake bundle of the decode queue.
//   master : the queue (accepts in_*, presents out_*)
//   slave  : the environment (IF stage drives in_*, decode drives out_ready)
//
// Handshake rule on both sides: a transfer happens on a rising clk edge where
// valid and ready are both 1. valid never depends combinationally on ready;
// the payload is only meaningful while valid = 1 (out_* read zero otherwise).
// Downstream acceptance of the head is additionally gated by the load-use
// hazard inputs of the queue itself.
interface id_queue_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [INST_WIDTH-1:0] in_inst;

   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic [INST_WIDTH-1:0] out_inst;
   logic [4:0]            out_rs;
   logic [4:0]            out_rt;
   logic [2:0]            out_op_type;

   modport master (
      input  in_valid, in_addr, in_inst, out_ready,
      output in_ready, out_valid, out_addr, out_inst, out_rs, out_rt, out_op_type
   );

   modport slave (
      output in_valid, in_addr, in_inst, out_ready,
      input  in_ready, out_valid, out_addr, out_inst, out_rs, out_rt, out_op_type
   );
endinterface

// File: rtl/id_queue_predecode.sv
// id_predecode
// Combinational pre-decode of one instruction word's upper fields.
//   hi_bits : instruction bits [31:16] (opcode, rs, rt)
//   rs, rt  : register fields
//   op_type : one-hot {R,I,J}
// Only the upper half is taken so a second decode lane can reuse it as is.
module id_predecode
   import id_queue_pkg::*;
(
   input  logic [OPCODE_MSB:RT_LSB] hi_bits,
   output logic [4:0]               rs,
   output logic [4:0]               rt,
   output logic [2:0]               op_type
);

   assign rs      = hi_bits[RS_MSB:RS_LSB];
   assign rt      = hi_bits[RT_MSB:RT_LSB];
   assign op_type = op_type_of(hi_bits[OPCODE_MSB:OPCODE_LSB]);

endmodule

// File: rtl/id_queue.sv
// id_queue
// Instruction decode queue between IF and ID. Buffers up to DEPTH fetched
// instructions, presents the oldest one show-ahead with pre-decoded fields,
// holds it under load-use hazards, and handles branch flush with optional
// delay-slot retention.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   q (master)        : fetch in_* handshake and decode out_* handshake
//   load_related_1/2  : load-use hazard on operand 1/2 (blocks the pop)
//   id_stall_request  : head present and a hazard is active
//   flush, keep_slot  : branch taken; keep_slot retains the oldest survivor
//   count             : occupancy
//   stall_cycles      : saturating count of stall-request cycles
module id_queue
   import id_queue_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   id_queue_if.master              q,
   input  logic                    load_related_1,
   input  logic                    load_related_2,
   output logic                    id_stall_request,
   input  logic                    flush,
   input  logic                    keep_slot,
   output logic [$clog2(DEPTH):0]  count,
   output logic [CNT_WIDTH-1:0]    stall_cycles
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]     DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]     CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] STALL_ONE = CNT_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [DEPTH];

   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W-1:0] rd_ptr_n, wr_ptr_n;
   logic [PTR_W:0]   count_n, after_pop;

   logic hazard, push, pop;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [INST_WIDTH-1:0] head_inst;
   logic [4:0]            head_rs, head_rt;
   logic [2:0]            head_type;

   // in_ready looks only at rst and the registered count.
   assign q.in_ready  = rst & (count < DEPTH_C);
   assign q.out_valid = (count != '0);

   assign hazard           = load_related_1 | load_related_2;
   assign id_stall_request = q.out_valid & hazard;
   assign push             = q.in_valid & q.in_ready;
   assign pop              = q.out_valid & q.out_ready & ~hazard;

   // Next-state: normal push/pop first, then flush overrides the result.
   always_comb begin
      rd_ptr_n  = pop  ? rd_ptr + PTR_ONE : rd_ptr;
      wr_ptr_n  = push ? wr_ptr + PTR_ONE : wr_ptr;
      after_pop = pop  ? count - CNT_ONE  : count;
      count_n   = push ? after_pop + CNT_ONE : after_pop;
      if (flush) begin
         if (!keep_slot) begin
            count_n  = '0;
            rd_ptr_n = wr_ptr_n;
         end else if (after_pop != '0) begin
            // Oldest survivor is an already-stored entry at the new head.
            count_n  = CNT_ONE;
            wr_ptr_n = rd_ptr_n + PTR_ONE;
         end else if (push) begin
            // Only survivor is the entry being written this cycle.
            count_n  = CNT_ONE;
            rd_ptr_n = wr_ptr;
            wr_ptr_n = wr_ptr + PTR_ONE;
         end else begin
            count_n  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr_n;
         wr_ptr <= wr_ptr_n;
         count  <= count_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (id_stall_request && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + STALL_ONE;
      end
   end

   // Payload storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= q.in_addr;
         inst_mem[wr_ptr] <= q.in_inst;
      end
   end

   assign head_addr = addr_mem[rd_ptr];
   assign head_inst = inst_mem[rd_ptr];

   id_predecode u_predecode (
      .hi_bits (head_inst[OPCODE_MSB:RT_LSB]),
      .rs      (head_rs),
      .rt      (head_rt),
      .op_type (head_type)
   );

   assign q.out_addr    = q.out_valid ? head_addr : '0;
   assign q.out_inst    = q.out_valid ? head_inst : '0;
   assign q.out_rs      = q.out_valid ? head_rs   : '0;
   assign q.out_rt      = q.out_valid ? head_rt   : '0;
   assign q.out_op_type = q.out_valid ? head_type : '0;

endmodule

// File: tb/tb_id_queue.sv
module tb_id_queue;

   localparam int AW    = 32;
   localparam int IW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_queue_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) q_if ();

   logic          load_related_1, load_related_2;
   logic          flush, keep_slot;
   logic          id_stall_request;
   logic [2:0]    count;
   logic [CW-1:0] stall_cycles;

   id_queue #(
      .ADDR_WIDTH (AW),
      .INST_WIDTH (IW),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .q                (q_if.master),
      .load_related_1   (load_related_1),
      .load_related_2   (load_related_2),
      .id_stall_request (id_stall_request),
      .flush            (flush),
      .keep_slot        (keep_slot),
      .count            (count),
      .stall_cycles     (stall_cycles)
   );

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_bad   = 0;
   logic [AW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [AW-1:0] addr, input logic [IW-1:0] inst);
      q_if.in_valid = 1'b1;
      q_if.in_addr  = addr;
      q_if.in_inst  = inst;
      tick();
      q_if.in_valid = 1'b0;
      #1;
   endtask

   task automatic drain_one();
      q_if.out_ready = 1'b1;
      tick();
      q_if.out_ready = 1'b0;
      #1;
   endtask

   logic [IW-1:0] pd_inst [3] = '{32'h0000_0020, 32'h0800_0010, 32'h8C22_0004};
   logic [2:0]    pd_type [3] = '{3'b100, 3'b001, 3'b010};

   initial begin
      rst            = 1'b0;
      q_if.in_valid  = 1'b0;
      q_if.in_addr   = '0;
      q_if.in_inst   = '0;
      q_if.out_ready = 1'b0;
      load_related_1 = 1'b1;
      load_related_2 = 1'b0;
      flush          = 1'b0;
      keep_slot      = 1'b0;

      // ---- reset state ----
      #2;
      check("rst_count",     count, 0);
      check("rst_out_valid", q_if.out_valid, 0);
      check("rst_in_ready",  q_if.in_ready, 0);
      check("rst_stall_req", id_stall_request, 0);
      check("rst_stall_cnt", stall_cycles, 0);
      check("rst_out_addr",  q_if.out_addr, 0);
      check("rst_out_type",  q_if.out_op_type, 0);
      load_related_1 = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("in_ready_after_rst", q_if.in_ready, 1);

      // ---- fill / drain ----
      for (int i = 0; i < DEPTH; i++) begin
         q_if.in_valid = 1'b1;
         q_if.in_addr  = 32'h100 + 32'(4 * i);
         q_if.in_inst  = 32'($urandom_range(0, 255));
         exp_q.push_back(q_if.in_addr);
         if (i == 0) check("no_bypass", q_if.out_valid, 0);
         tick();
         if (i == 0) check("first_head", q_if.out_addr, 32'h100);
      end
      q_if.in_valid = 1'b0;
      #1;
      check("full_count",    count, 4);
      check("full_in_ready", q_if.in_ready, 0);
      q_if.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         check("drain_addr", q_if.out_addr, exp_q.pop_front());
         tick();
      end
      q_if.out_ready = 1'b0;
      #1;
      check("drained_count", count, 0);
      check("drained_valid", q_if.out_valid, 0);
      check("drained_addr",  q_if.out_addr, 0);

      // ---- simultaneous push and pop ----
      push_one(32'h180, 32'h0000_0020);
      q_if.in_valid  = 1'b1;
      q_if.in_addr   = 32'h184;
      q_if.out_ready = 1'b1;
      tick();
      q_if.in_valid  = 1'b0;
      q_if.out_ready = 1'b0;
      #1;
      check("pushpop_count", count, 1);
      check("pushpop_head",  q_if.out_addr, 32'h184);
      drain_one();

      // ---- load-use stall ----
      push_one(32'h200, 32'h8C22_0004);
      q_if.out_ready = 1'b1;
      load_related_2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_req",  id_stall_request, 1);
         check("stall_head", q_if.out_addr, 32'h200);
         tick();
      end
      load_related_2 = 1'b0;
      #1;
      check("stall_cycles_3", stall_cycles, 3);
      check("stall_req_off",  id_stall_request, 0);
      check("stall_head_rel", q_if.out_addr, 32'h200);
      tick();
      q_if.out_ready = 1'b0;
      #1;
      check("stall_popped", count, 0);

      // ---- flush keeping the delay slot ----
      push_one(32'h300, 32'h1000_0004);
      push_one(32'h304, 32'h0000_0020);
      push_one(32'h308, 32'h0000_0020);
      q_if.out_ready = 1'b1;
      flush          = 1'b1;
      keep_slot      = 1'b1;
      tick();
      q_if.out_ready = 1'b0;
      flush          = 1'b0;
      keep_slot      = 1'b0;
      #1;
      check("flush_slot_count", count, 1);
      check("flush_slot_head",  q_if.out_addr, 32'h304);
      drain_one();
      check("flush_slot_drain", count, 0);

      // ---- flush into empty queue with a push ----
      q_if.in_valid = 1'b1;
      q_if.in_addr  = 32'h400;
      flush         = 1'b1;
      tick();
      q_if.in_valid = 1'b0;
      flush         = 1'b0;
      #1;
      check("flush_noslot_count", count, 0);
      check("flush_noslot_valid", q_if.out_valid, 0);
      q_if.in_valid = 1'b1;
      q_if.in_addr  = 32'h404;
      flush         = 1'b1;
      keep_slot     = 1'b1;
      tick();
      q_if.in_valid = 1'b0;
      flush         = 1'b0;
      keep_slot     = 1'b0;
      #1;
      check("flush_push_count", count, 1);
      check("flush_push_head",  q_if.out_addr, 32'h404);
      drain_one();

      // ---- pre-decode ----
      for (int i = 0; i < 3; i++) push_one(32'h500 + 32'(4 * i), pd_inst[i]);
      q_if.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("pd_inst", q_if.out_inst, pd_inst[i]);
         check("pd_type", q_if.out_op_type, pd_type[i]);
         if (i == 2) begin
            check("pd_rs", q_if.out_rs, 1);
            check("pd_rt", q_if.out_rt, 2);
         end
         tick();
      end
      q_if.out_ready = 1'b0;
      #1;

      // ---- async reset while full and stalled ----
      for (int i = 0; i < DEPTH; i++) push_one(32'h600 + 32'(4 * i), 32'h0000_0020);
      load_related_1 = 1'b1;
      q_if.out_ready = 1'b1;
      tick();
      tick();
      check("stall_cycles_5", stall_cycles, 5);
      check("full_again",     count, 4);
      #2;
      rst = 1'b0;
      #1;
      check("arst_count",     count, 0);
      check("arst_valid",     q_if.out_valid, 0);
      check("arst_stall_cnt", stall_cycles, 0);
      check("arst_in_ready",  q_if.in_ready, 0);
      check("arst_stall_req", id_stall_request, 0);
      load_related_1 = 1'b0;
      q_if.out_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("arst_release_ready", q_if.in_ready, 1);
      check("arst_release_count", count, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
